// File: rtl/cmd_tx_scheduler.sv
`default_nettype none
// cmd_tx_scheduler: round-robin arbiter sharing one serial command line between 4 requesters.
// Frames are start bit, 8 data bits LSB first, stop bit, then an idle-high gap.
module cmd_tx_scheduler #(
   parameter int BIT_CYCLES = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] cmd_bus,
   output logic [3:0]  grant,
   output logic        err,
   output logic        busy,
   output logic        serial
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [7:0] BIT_RELOAD = 8'(BIT_CYCLES - 1);
   localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  rr_q, rr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  byte_q, byte_d;
   logic        serial_q, serial_d;
   logic        busy_q, busy_d;

   logic [1:0]  win;
   logic        win_vld;
   logic [7:0]  win_byte;
   logic        op_ok;
   logic        arb;

   // Descending scan so the requester closest to rr_q is the last (winning) assignment.
   always_comb begin
      win     = rr_q;
      win_vld = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (req[rr_q + 2'(k)]) begin
            win     = rr_q + 2'(k);
            win_vld = 1'b1;
         end
      end
   end

   assign win_byte = cmd_bus[{win, 3'b000} +: 8];
   assign op_ok    = (win_byte[7:4] == 4'b0001) || (win_byte[7:4] == 4'b0010) ||
                     (win_byte[7:4] == 4'b0100);
   assign arb      = (state_q == S_IDLE) && win_vld && !reset;

   assign grant  = arb ? (4'b0001 << win) : 4'b0000;
   assign err    = arb && !op_ok;
   assign busy   = busy_q;
   assign serial = serial_q;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      byte_d   = byte_q;
      serial_d = serial_q;
      busy_d   = busy_q;

      case (state_q)
         S_IDLE: begin
            serial_d = 1'b1;
            busy_d   = 1'b0;
            if (arb) begin
               rr_d = win + 2'd1;
               // Invalid opcodes are acknowledged (grant+err) but never framed.
               if (op_ok) begin
                  byte_d   = win_byte;
                  serial_d = 1'b0;
                  busy_d   = 1'b1;
                  cnt_d    = BIT_RELOAD;
                  state_d  = S_START;
               end
            end
         end

         S_START: begin
            if (cnt_q == 8'd0) begin
               state_d  = S_DATA;
               idx_d    = 3'd0;
               serial_d = byte_q[0];
               cnt_d    = BIT_RELOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         S_DATA: begin
            if (cnt_q == 8'd0) begin
               cnt_d = BIT_RELOAD;
               if (idx_q == 3'd7) begin
                  state_d  = S_STOP;
                  serial_d = 1'b1;
               end else begin
                  idx_d    = idx_q + 3'd1;
                  serial_d = byte_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         S_STOP: begin
            if (cnt_q == 8'd0) begin
               if (GAP_CYCLES == 0) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = GAP_RELOAD;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         S_GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         default: begin
            state_d  = S_IDLE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_q     <= 2'd0;
         cnt_q    <= 8'd0;
         idx_q    <= 3'd0;
         byte_q   <= 8'd0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         byte_q   <= byte_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmd_tx_scheduler.sv
`default_nettype none
// tb_cmd_tx_scheduler: directed + random stimulus on two parameterisations,
// checked cycle by cycle against a frame-level reference model.
module tb_cmd_tx_scheduler;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [3:0]  req_a, req_b, grant_a, grant_b;
   logic [31:0] cmd_a, cmd_b;
   logic        err_a, err_b, busy_a, busy_b, serial_a, serial_b;

   cmd_tx_scheduler #(.BIT_CYCLES(2), .GAP_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .req(req_a), .cmd_bus(cmd_a),
      .grant(grant_a), .err(err_a), .busy(busy_a), .serial(serial_a)
   );

   cmd_tx_scheduler #(.BIT_CYCLES(1), .GAP_CYCLES(0)) dut_fast (
      .clock(clock), .reset(reset), .req(req_b), .cmd_bus(cmd_b),
      .grant(grant_b), .err(err_b), .busy(busy_b), .serial(serial_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
   endtask

   // Reference model: per DUT, cycles of frame left, elapsed cycles, latched byte, rr pointer.
   int          bit_c[2] = '{2, 1};
   int          gap_c[2] = '{4, 0};
   int          left[2];
   int          t_el[2];
   logic [7:0]  m_byte[2];
   int          rr[2];
   logic [3:0]  m_gnt[2];
   logic [3:0]  cur_req[2];
   logic [31:0] cur_cmd[2];

   task automatic model_cycle(input int d, input logic [3:0] o_g, input logic o_e,
                              input logic o_b, input logic o_s);
      int         win;
      int         bc;
      logic [7:0] by;
      logic       ok;
      logic [3:0] eg;
      logic       ee, eb, es;
      string      nm;
      nm  = (d == 0) ? "a" : "b";
      bc  = bit_c[d];
      win = -1;
      by  = 8'h00;
      ok  = 1'b0;
      if (left[d] == 0) begin
         if (!reset)
            for (int k = 0; k < 4; k++)
               if (win < 0 && cur_req[d][(rr[d] + k) % 4]) win = (rr[d] + k) % 4;
         if (win >= 0) begin
            by = cur_cmd[d][8*win +: 8];
            ok = (by[7:4] == 4'h1) || (by[7:4] == 4'h2) || (by[7:4] == 4'h4);
         end
         eg = (win >= 0) ? 4'(1 << win) : 4'b0000;
         ee = (win >= 0) && !ok;
         eb = 1'b0;
         es = 1'b1;
      end else begin
         eg = 4'b0000;
         ee = 1'b0;
         eb = 1'b1;
         if (t_el[d] < bc)          es = 1'b0;
         else if (t_el[d] < 9 * bc) es = m_byte[d][(t_el[d] - bc) / bc];
         else                       es = 1'b1;
      end
      chk({"grant_", nm},  32'(o_g), 32'(eg));
      chk({"err_", nm},    32'(o_e), 32'(ee));
      chk({"busy_", nm},   32'(o_b), 32'(eb));
      chk({"serial_", nm}, 32'(o_s), 32'(es));
      m_gnt[d] = eg;
      if (reset) begin
         left[d] = 0;
         rr[d]   = 0;
      end else if (left[d] > 0) begin
         left[d]--;
         t_el[d]++;
      end else if (win >= 0) begin
         rr[d] = (win + 1) % 4;
         if (ok) begin
            m_byte[d] = by;
            left[d]   = 10 * bc + gap_c[d];
            t_el[d]   = 0;
         end
      end
   endtask

   task automatic step(input logic [3:0] ra, input logic [31:0] ca,
                       input logic [3:0] rb, input logic [31:0] cb, input logic rst);
      req_a = ra; cmd_a = ca; req_b = rb; cmd_b = cb; reset = rst;
      cur_req[0] = ra; cur_cmd[0] = ca; cur_req[1] = rb; cur_cmd[1] = cb;
      @(negedge clock);
      model_cycle(0, grant_a, err_a, busy_a, serial_a);
      model_cycle(1, grant_b, err_b, busy_b, serial_b);
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] rbyte();
      int         sel;
      logic [3:0] op;
      sel = $urandom_range(0, 4);
      case (sel)
         0:       op = 4'h1;
         1:       op = 4'h2;
         2:       op = 4'h4;
         default: op = 4'($urandom);
      endcase
      return {op, 4'($urandom)};
   endfunction

   logic [3:0]  ra, rb;
   logic [31:0] ca;
   logic [3:0]  rq[2];
   logic [31:0] cm[2];
   logic        rst_r;

   initial begin
      reset = 1'b1; req_a = 4'b0; req_b = 4'b0; cmd_a = 32'b0; cmd_b = 32'b0;
      for (int d = 0; d < 2; d++) begin
         left[d] = 0; t_el[d] = 0; rr[d] = 0; m_byte[d] = 8'h00; m_gnt[d] = 4'b0;
      end
      repeat (2) @(posedge clock);
      #1;
      step(4'b0, 32'h0, 4'b0, 32'h0, 1'b1);

      // Single 0x25 frame on a; back-to-back frames on fast b with req held.
      ra = 4'b0001;
      repeat (40) begin
         step(ra, 32'h0000_0025, 4'b0001, 32'h0000_004A, 1'b0);
         ra = ra & ~m_gnt[0];
      end

      // All four requesting continuously from rr=0.
      step(4'b0, 32'h0, 4'b0, 32'h0, 1'b1);
      repeat (110) step(4'b1111, 32'h2F40_2310, 4'b0, 32'h0, 1'b0);

      // Invalid opcode on requester 2, then requesters 0 and 3 compete.
      step(4'b0, 32'h0, 4'b0, 32'h0, 1'b1);
      ra = 4'b0100;
      repeat (5) begin
         step(ra, 32'h0085_0000, 4'b0, 32'h0, 1'b0);
         if (m_gnt[0] != 4'b0) ra = 4'b0000;
      end
      ra = 4'b1001;
      repeat (60) begin
         step(ra, 32'h1000_0010, 4'b0, 32'h0, 1'b0);
         ra = ra & ~m_gnt[0];
      end

      // Reset during data bit 3, then a normal grant to requester 1.
      ra = 4'b0001;
      repeat (5) begin
         step(ra, 32'h0000_0025, 4'b0, 32'h0, 1'b0);
         if (m_gnt[0] != 4'b0) break;
      end
      repeat (9) step(4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
      step(4'b0, 32'h0, 4'b0, 32'h0, 1'b1);
      ra = 4'b0010;
      repeat (30) begin
         step(ra, 32'h0000_2100, 4'b0, 32'h0, 1'b0);
         ra = ra & ~m_gnt[0];
      end

      // cmd_bus changes after the grant edge must not affect the frame.
      ra = 4'b0001;
      ca = 32'h0000_0026;
      repeat (5) begin
         step(ra, ca, 4'b0, 32'h0, 1'b0);
         if (m_gnt[0] != 4'b0) break;
      end
      ra = 4'b0000;
      repeat (2) step(ra, ca, 4'b0, 32'h0, 1'b0);
      ca = 32'h0000_0041;
      repeat (30) step(ra, ca, 4'b0, 32'h0, 1'b0);

      // Random traffic with withdrawals, changing command bytes and rare resets.
      rq[0] = 4'b0; rq[1] = 4'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < 2; d++) begin
            rq[d] = rq[d] & ~m_gnt[d];
            for (int i = 0; i < 4; i++) begin
               if (!rq[d][i] && $urandom_range(0, 5) == 0)      rq[d][i] = 1'b1;
               else if (rq[d][i] && $urandom_range(0, 60) == 0) rq[d][i] = 1'b0;
            end
            cm[d] = {rbyte(), rbyte(), rbyte(), rbyte()};
         end
         rst_r = ($urandom_range(0, 399) == 0);
         step(rq[0], cm[0], rq[1], cm[1], rst_r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmd_tx_scheduler.md
Name: cmd_tx_scheduler

Overview:
Round-robin scheduler that shares one serial command line between 4 requesters feeding the 7-segment display receiver.
- Accepts one command byte per requester and validates the opcode nibble.
- Serializes granted bytes as frames: start bit, 8 data bits LSB first, stop bit, then an idle gap.
- Opcode encoding is the receiver's: 0001 = clear, 0010 = load data nibble, 0100 = show; other opcodes are rejected.

Parameters:
- BIT_CYCLES, 2, clock cycles each serial bit is held (1..255).
- GAP_CYCLES, 4, idle-high cycles after stop bit before next arbitration (0..255).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; held until granted.
- cmd_bus  input  32  command bytes; requester i uses bits [8i+7:8i].
- grant  output  4  one-hot, one-cycle pulse to the winning requester.
- err  output  1  one-cycle pulse with grant when the granted opcode is invalid.
- busy  output  1  high while a frame or gap is in progress.
- serial  output  1  registered serial line, idle high.

Behaviour:
- Reset (synchronous, active-high; clock, reset as above): serial=1, grant=0, err=0, busy=0, state=IDLE, rr_ptr=0, counters=0.
- Reset mid-frame aborts the frame: serial returns high on the next edge and no grant is reissued.
- States: IDLE, START, DATA, STOP, GAP.
- IDLE:
  - serial=1. If req!=0, winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod 4.
  - On that edge: grant[winner]=1 for exactly one cycle, byte latched from cmd_bus, rr_ptr <= (winner+1) mod 4.
- Valid opcode (byte[7:4] in {0001, 0010, 0100}):
  - On the grant edge: serial<=0, busy<=1, state<=START.
- Invalid opcode:
  - err=1 in the same cycle as grant; no frame is sent; serial stays 1; busy stays 0; state stays IDLE.
  - rr_ptr still advances.
  - The next arbitration may occur on the following edge.
- START: serial=0 for BIT_CYCLES cycles, then DATA.
- DATA: bit k (k=0..7, LSB first) held for BIT_CYCLES cycles; after bit 7, go to STOP.
- STOP: serial=1 for BIT_CYCLES cycles. Then GAP, or IDLE directly if GAP_CYCLES=0.
- GAP: serial=1 for GAP_CYCLES cycles, then IDLE; busy drops on the edge entering IDLE.
- Frame timing:
  - Serial low starts the cycle after the grant edge.
  - Busy is high for 10*BIT_CYCLES+GAP_CYCLES cycles, i.e. 24 with defaults.
- Requests during busy are not sampled.
- A req deasserted before its grant is withdrawn; the scheduler keeps no memory of it.
- cmd_bus is sampled only on the grant edge; later changes do not affect the frame in flight.
- Simultaneous requests: exactly one grant per arbitration, and no requester waits more than 3 frames while holding req.
- Bit timing uses one down-counter (8 bits) and one bit index (3 bits); the counters wrap only via reload, never free-run.

Test Plan:
1. Reset, then req=0001, cmd_bus[7:0]=0x25 → grant=0001 for 1 cycle; serial 0 for 2 cycles, then bits 1,0,1,0,0,1,0,0 at 2 cycles each, then 1; busy high for 24 cycles; err=0.
2. req=1111 held, bytes 0x10/0x23/0x40/0x2F → grants in order 0001, 0010, 0100, 1000, then 0001 again; each grant spaced 25 cycles (24 busy + 1 IDLE arbitration edge).
3. req=0100 with byte 0x85 (invalid opcode) → grant=0100 and err=1 same cycle; serial stays 1; busy stays 0; rr_ptr=3, so a following req=1001 grants 1000 first.
4. Assert reset during DATA bit 3 of a frame → serial=1, busy=0, grant=0 next cycle; rr_ptr=0; after release, req=0010 is granted normally.
5. cmd_bus changes from 0x26 to 0x41 two cycles after grant → transmitted bits still match 0x26 (0,1,1,0,0,1,0,0).
6. BIT_CYCLES=1, GAP_CYCLES=0, back-to-back req=0001 → busy high for 10 cycles; next grant on the 11th cycle after the first grant.
